// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets NREQ compute lanes share
// one ALU. Non-multiply ops return one cycle after acceptance; multiply waits
// MUL_LAT cycles, so a pipelined multiplier can sit behind this block.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_left,
    input  logic [WIDTH*NREQ-1:0]   req_right,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [WIDTH-1:0]        resp_data
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // A multiply only needs the wait state when it takes more than one cycle.
    localparam bit MUL_MULTI = (MUL_LAT > 1);
    localparam int CW        = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [IDW-1:0]     rr_ptr_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   mul_left_reg;
    logic [WIDTH-1:0]   mul_right_reg;
    logic [IDW-1:0]     resp_id_reg;
    logic [WIDTH-1:0]   resp_data_reg;

    logic [2:0]         op_arr    [NREQ];
    logic [WIDTH-1:0]   left_arr  [NREQ];
    logic [WIDTH-1:0]   right_arr [NREQ];

    logic [IDW-1:0]     grant_idx;
    logic               any_valid;
    logic               can_accept;
    logic               fire;
    logic [2:0]         g_op;
    logic [WIDTH-1:0]   g_left;
    logic [WIDTH-1:0]   g_right;
    logic               g_is_mul_wait;

    // Unpack the flat per-requester buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_arr[gi]    = req_op[3*gi +: 3];
            assign left_arr[gi]  = req_left[WIDTH*gi +: WIDTH];
            assign right_arr[gi] = req_right[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // (p + k) mod NREQ for the round-robin scan; k is always < NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // The shared ALU. Shifts are logical and saturate to zero at >= WIDTH.
    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic             big;
        big = ({1'b0, b} >= (WIDTH+1)'(WIDTH));
        res = '0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_MUL: res = a * b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: res = big ? '0 : (a << b);
            OP_SHR: res = big ? '0 : (a >> b);
            default: res = '0;
        endcase
        return res;
    endfunction

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_valid && req_valid[wrap_add(rr_ptr_reg, k)]) begin
                any_valid = 1'b1;
                grant_idx = wrap_add(rr_ptr_reg, k);
            end
        end
    end

    assign g_op          = op_arr[grant_idx];
    assign g_left        = left_arr[grant_idx];
    assign g_right       = right_arr[grant_idx];
    assign g_is_mul_wait = MUL_MULTI && (g_op == OP_MUL);

    // Output decode: accept window, one-hot ready, and response valid.
    always_comb begin
        can_accept = (state_reg == IDLE) || ((state_reg == HOLD) && resp_ready);
        fire       = can_accept && any_valid && reset_n;
        req_ready  = '0;
        if (fire) begin
            req_ready[grant_idx] = 1'b1;
        end
        resp_valid = (state_reg == HOLD);
    end

    // Next-state logic: a grant always decides the next state, else the
    // multiply countdown or the output handshake does.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (fire) begin
                    state_next = g_is_mul_wait ? MULW : HOLD;
                end
            end
            MULW: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (fire) begin
                    state_next = g_is_mul_wait ? MULW : HOLD;
                end else if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: pointer advance, operand capture, multiply countdown, result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            mul_left_reg  <= '0;
            mul_right_reg <= '0;
            resp_id_reg   <= '0;
            resp_data_reg <= '0;
        end else if (fire) begin
            rr_ptr_reg  <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            resp_id_reg <= grant_idx;
            if (g_is_mul_wait) begin
                mul_left_reg  <= g_left;
                mul_right_reg <= g_right;
                cnt_reg       <= CW'(MUL_LAT-1);
            end else begin
                resp_data_reg <= alu_f(g_op, g_left, g_right);
            end
        end else if (state_reg == MULW) begin
            if (cnt_reg == '0) begin
                resp_data_reg <= mul_left_reg * mul_right_reg;
            end else begin
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end

    assign resp_id   = resp_id_reg;
    assign resp_data = resp_data_reg;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU (add, sub, multiply, and, or, xor, shift-left, shift-right) among NREQ requesters.
- Per-requester valid/ready request channels; round-robin grant; single registered response channel tagged with requester id.
- Multiply is modelled as multi-cycle (MUL_LAT) so the block can front a pipelined multiplier; all other ops complete in one cycle.
- Sits between compute lanes and a single physical ALU instance to save area.

Parameters:
- WIDTH, 32, operand/result width.
- NREQ, 4, number of requesters (>=2).
- MUL_LAT, 2, cycles from multiply acceptance to resp_valid (>=1).
- IDW, $clog2(NREQ), width of resp_id.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  input  3*NREQ  op for requester i in [3i+2:3i]: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR.
- req_left  input  WIDTH*NREQ  left operand, slice i.
- req_right  input  WIDTH*NREQ  right operand/shift amount, slice i.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  index of requester the result belongs to.
- resp_data  output  WIDTH  result.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset (async assert, sync-safe deassert):
  - state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_data=0, mul counter=0.
  - req_ready is 0 while reset_n=0.
  - Reset mid-multiply discards the operation; no response is produced.
- States: IDLE (output empty), MULW (multiply pending), HOLD (resp_valid=1, awaiting resp_ready).
- can_accept = (state==IDLE) || (state==HOLD && resp_ready). Never true in MULW.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ; first set bit is the winner g.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and resp_ready.
- Handshake at index g when req_valid[g] && req_ready[g]:
  - rr_ptr <= (g+1) mod NREQ.
  - If no handshake occurs, rr_ptr holds.
- Non-MUL op accepted: next cycle state=HOLD, resp_valid=1, resp_id=g, resp_data=f(op, left, right). Latency is 1 cycle.
- MUL op accepted:
  - Operands and id are captured; state=MULW; counter loads MUL_LAT-1.
  - Counter decrements each cycle; when it is 0, the next edge enters HOLD with resp_data = low WIDTH bits of left*right.
  - resp_valid therefore rises exactly MUL_LAT cycles after the handshake edge.
  - MUL_LAT=1 behaves like other ops.
- HOLD:
  - resp_id and resp_data are stable until resp_valid && resp_ready.
  - On that handshake with no new grant, state=IDLE and resp_valid=0.
  - With a simultaneous grant, the new result replaces the old one the next cycle, giving back-to-back throughput of 1 op/cycle for non-MUL ops.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^WIDTH (two's complement).
  - SHL and SHR are logical; a shift amount >= WIDTH yields 0.
  - Logic ops are bitwise.
- Inputs of non-granted requesters are ignored. A requester may drop req_valid without penalty before it is granted.
- Starvation bound: a continuously valid requester is granted within NREQ handshakes.

Test Plan:
- Reset, then req_valid=4'b0001, ADD 5+7, resp_ready=1 -> req_ready=4'b0001 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=12; following cycle resp_valid=0.
- All four requesters valid continuously with non-MUL ops, resp_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; one response per cycle with matching ids and data (e.g. SUB 3-5 = 0xFFFFFFFE).
- Requester 2 MUL 0x10000*0x10003, MUL_LAT=2 -> resp_valid rises 2 cycles after handshake, resp_data=0x00030000; req_ready stays all-zero during MULW despite pending valids.
- Hold resp_ready=0 for 3 cycles with result 0xAB pending -> resp_valid, resp_id and resp_data stable; req_ready=0; on resp_ready=1 a waiting request is granted in the same cycle.
- SHL 1 by 32 -> 0; SHR 0x80000000 by 31 -> 1; XOR 0xF0F0 with 0xFFFF -> 0x0F0F.
- Assert reset_n=0 mid-MULW, then release -> resp_valid=0, rr_ptr=0, no stale response; the next request from requester 0 is granted first.
